// File: rtl/ip_hdr_tx.sv
// ip_hdr_tx: prepends a module header plus Ethernet/IPv4 headers (with computed checksum) to a payload stream
// Ports:
//   clk, reset           rising-edge clock, asynchronous active-low reset
//   start                one-cycle packet request, honoured only while idle
//   mac_*, ip_*, *_port  header fields, captured on an accepted start
//   pl_data/ctrl/vld/rd  payload input; nonzero pl_ctrl marks the last word
//   out_data/ctrl/wr     output word, valid when out_wr; zero otherwise
//   out_rdy              downstream accepts a word this cycle
//   busy                 a packet is in progress
module ip_hdr_tx #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH/8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [47:0]           mac_da,
  input  logic [47:0]           mac_sa,
  input  logic [31:0]           ip_src,
  input  logic [31:0]           ip_dst,
  input  logic [15:0]           ip_len,
  input  logic [15:0]           ip_id,
  input  logic [7:0]            ip_ttl,
  input  logic [7:0]            ip_proto,
  input  logic [15:0]           src_port,
  input  logic [15:0]           dst_port,
  input  logic [DATA_WIDTH-1:0] pl_data,
  input  logic [CTRL_WIDTH-1:0] pl_ctrl,
  input  logic                  pl_vld,
  output logic                  pl_rd,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy,
  output logic                  busy
);
  typedef enum logic [3:0] {IDLE, CALC, MOD_HDR, W1, W2, W3, W4, W5, PAYLOAD} state_t;
  state_t state;
  logic [47:0] da_q, sa_q;
  logic [31:0] src_q, dst_q;
  logic [15:0] len_q, id_q, sport_q, dport_q, csum_q;
  logic [7:0] ttl_q, proto_q;
  logic [19:0] sum;
  logic [16:0] fold1;
  logic [15:0] fold2, byte_len, word_len;
  logic hdr_st, pl_st, xfer;
  logic [DATA_WIDTH-1:0] word;
  logic [CTRL_WIDTH-1:0] ctrl;
  // Nine 16-bit operands fit in 20 bits; two folds always absorb every carry.
  always_comb begin
    sum = 20'(16'h4500) + 20'(len_q) + 20'(id_q) + 20'(16'h4000) + 20'({ttl_q, proto_q})
        + 20'(src_q[31:16]) + 20'(src_q[15:0]) + 20'(dst_q[31:16]) + 20'(dst_q[15:0]);
    fold1 = 17'(sum[15:0]) + 17'(sum[19:16]);
    fold2 = fold1[15:0] + 16'(fold1[16]);
    byte_len = len_q + 16'd14;
    word_len = 16'((17'(byte_len) + 17'd7) >> 3);
  end
  assign hdr_st = state inside {MOD_HDR, W1, W2, W3, W4};
  assign pl_st  = state inside {W5, PAYLOAD};
  assign xfer   = pl_vld & out_rdy;
  assign out_wr = hdr_st ? out_rdy : pl_st & xfer;
  assign pl_rd  = pl_st & xfer;
  assign busy   = state != IDLE;
  always_comb begin
    word = '0;
    ctrl = '0;
    case (state)
      MOD_HDR: begin
        word = {dport_q, word_len, sport_q, byte_len};
        ctrl = '1;
      end
      W1: word = {da_q, sa_q[47:32]};
      W2: word = {sa_q[31:0], 16'h0800, 8'h45, 8'h00};
      W3: word = {len_q, id_q, 16'h4000, ttl_q, proto_q};
      W4: word = {csum_q, src_q, dst_q[31:16]};
      // First payload word shares its top 16 bits with the tail of the IP header.
      W5: begin
        word = {dst_q[15:0], pl_data[47:0]};
        ctrl = pl_ctrl;
      end
      PAYLOAD: begin
        word = pl_data;
        ctrl = pl_ctrl;
      end
      default: ;
    endcase
  end
  assign out_data = out_wr ? word : '0;
  assign out_ctrl = out_wr ? ctrl : '0;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      da_q    <= '0;
      sa_q    <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      id_q    <= '0;
      ttl_q   <= '0;
      proto_q <= '0;
      sport_q <= '0;
      dport_q <= '0;
      csum_q  <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          da_q    <= mac_da;
          sa_q    <= mac_sa;
          src_q   <= ip_src;
          dst_q   <= ip_dst;
          len_q   <= ip_len;
          id_q    <= ip_id;
          ttl_q   <= ip_ttl;
          proto_q <= ip_proto;
          sport_q <= src_port;
          dport_q <= dst_port;
          state   <= CALC;
        end
        CALC: begin
          csum_q <= ~fold2;
          state  <= MOD_HDR;
        end
        MOD_HDR: if (out_rdy) state <= W1;
        W1: if (out_rdy) state <= W2;
        W2: if (out_rdy) state <= W3;
        W3: if (out_rdy) state <= W4;
        W4: if (out_rdy) state <= W5;
        W5: if (xfer) state <= (|pl_ctrl) ? IDLE : PAYLOAD;
        PAYLOAD: if (xfer && |pl_ctrl) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/ip_hdr_tx.md
IP_HDR_TX -- requirements
Module: ip_hdr_tx

Interface
REQ-001 Parameter DATA_WIDTH, default 64, data bus width; only 64 is supported.
REQ-002 Parameter CTRL_WIDTH, default DATA_WIDTH/8, ctrl bus width.
REQ-003 Ports, one per line (name  direction  width  meaning):
- clk  in  1  single clock; all logic is on its rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  one-cycle request to emit one packet; sampled only in IDLE.
- mac_da, mac_sa  in  48 each  Ethernet destination and source MAC.
- ip_src, ip_dst  in  32 each  IPv4 source and destination.
- ip_len, ip_id  in  16 each  IPv4 total length and identification.
- ip_ttl, ip_proto  in  8 each  IPv4 TTL and protocol.
- src_port, dst_port  in  16 each  module-header port fields.
- pl_data  in  64  payload word.
- pl_ctrl  in  8  payload ctrl; nonzero marks the last word (byte-valid marker).
- pl_vld  in  1  payload word available.
- pl_rd  out  1  payload word consumed this cycle.
- out_data  out  64  output bus data.
- out_ctrl  out  8  output bus ctrl.
- out_wr  out  1  output word valid and transferred this cycle.
- out_rdy  in  1  downstream can accept a word this cycle.
- busy  out  1  high in any state other than IDLE.

Function
REQ-004 States: IDLE, CALC, MOD_HDR, W1, W2, W3, W4, W5, PAYLOAD.
REQ-005 IDLE + start: latch all header inputs, go to CALC. start in any other state is ignored.
REQ-006 CALC: compute checksum in exactly one cycle, then go to MOD_HDR.
- Operands are the 16-bit ones'-complement sum of 0x4500, ip_len, ip_id, 0x4000, {ttl,proto}, src_hi, src_lo, dst_hi, dst_lo.
- Fold carries twice, invert, store.
- Result: first out_wr no earlier than start+2 cycles.
REQ-007 MOD_HDR through W4 each emit one word when out_rdy=1 (out_wr=1 that cycle), then advance. When out_rdy=0: out_wr=0 and the state holds.
REQ-008 MOD_HDR word: out_ctrl=0xFF, out_data={dst_port, word_len, src_port, byte_len}.
- byte_len = ip_len+14, modulo 2^16.
- word_len = (byte_len+7)>>3, computed 17-bit, truncated to 16.
REQ-009 Header words W1–W4 all have out_ctrl=0:
- W1 = {mac_da, mac_sa[47:32]}.
- W2 = {mac_sa[31:0], 0x0800, 0x45, 0x00}.
- W3 = {ip_len, ip_id, 0x4000, ip_ttl, ip_proto}.
- W4 = {checksum, ip_src, ip_dst[31:16]}.
REQ-010 W5 emits {ip_dst[15:0], pl_data[47:0]} with out_ctrl=pl_ctrl.
- Transfers only when out_rdy=1 and pl_vld=1; then pl_rd=1 and out_wr=1 in the same cycle.
- pl_data[63:48] of this word is discarded.
REQ-011 PAYLOAD passes pl_data/pl_ctrl unchanged under the same out_rdy&pl_vld rule.
REQ-012 pl_rd=0 in every state except W5 and PAYLOAD; pl_rd never asserts without out_wr.
REQ-013 In W5 or PAYLOAD, a transferred word with pl_ctrl!=0 goes to IDLE; otherwise W5 goes to PAYLOAD and PAYLOAD holds.
REQ-014 IDLE→CALC on start and X→IDLE on end-of-packet use no extra idle cycle: a start in the cycle after returning to IDLE is accepted.
REQ-015 When out_wr=0, out_data and out_ctrl are 0.

Reset
REQ-016 reset=0 asynchronously forces IDLE and drives out_wr=0, pl_rd=0, busy=0, out_data=0, out_ctrl=0, and clears latched fields and checksum to 0.
REQ-017 Reset asserted mid-packet abandons the packet: no further words are emitted, and the next packet requires a new start.
REQ-018 The first start is accepted on the first rising edge after reset deasserts.

Verification
REQ-019 Common stimulus: ip_len=0x0073, ip_id=0, ttl=0x40, proto=0x11, src=0xC0A80001, dst=0xC0A800C7, out_rdy=1, pl_vld=1.
- Required: MOD_HDR byte_len=0x0081, word_len=0x0011.
- Required: W3={0x0073,0x0000,0x4000,0x4011}.
- Required: W4={0xB861,0xC0A80001,0xC0A8}.
REQ-020 Single-word payload with pl_ctrl=0x20 on the first word -> W5 out_ctrl=0x20; exactly 6 out_wr pulses; busy drops the next cycle.
REQ-021 out_rdy toggled 0/1 every cycle across a 10-word payload -> the word sequence is identical to the stall-free run, and no word is duplicated or dropped.
REQ-022 pl_vld=0 for 3 cycles in PAYLOAD -> out_wr=0 and pl_rd=0 for those cycles; the packet resumes intact.
REQ-023 start pulsed while busy, and a back-to-back start in the cycle after end-of-packet -> the first is ignored and the second begins a new packet.
REQ-024 reset pulsed during W3 -> all outputs 0 immediately; after release, a new start yields a correct full packet.
